// File: rtl/quaternion_integrator.sv
// Attitude propagator: q <- q + 1/2 * q (x) (0,w) * dt using one time-shared multiplier,
// handing the unnormalized quaternion downstream and reloading from the renorm return path.
module quaternion_integrator #(
   parameter int unsigned DT_SHIFT = 8,
   parameter int unsigned ACC_W    = 36
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [15:0]      gx_in,
   input  logic signed [15:0]      gy_in,
   input  logic signed [15:0]      gz_in,
   input  logic                    renorm_valid,
   output logic                    renorm_ready,
   input  logic signed [15:0]      renorm_w,
   input  logic signed [15:0]      renorm_x,
   input  logic signed [15:0]      renorm_y,
   input  logic signed [15:0]      renorm_z,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [15:0]      w_out,
   output logic signed [15:0]      x_out,
   output logic signed [15:0]      y_out,
   output logic signed [15:0]      z_out,
   output logic                    sat_flag
);

   localparam int unsigned DW = 16;
   localparam int unsigned PW = 2 * DW;
   localparam int unsigned IW = 4;
   localparam int unsigned SH = 12 + 1 + DT_SHIFT;

   localparam logic [IW-1:0]           LAST_IDX = IW'(11);
   localparam logic signed [DW-1:0]    Q_MAX    = DW'(32767);
   localparam logic signed [DW-1:0]    Q_MIN    = DW'(-32768);
   localparam logic signed [ACC_W-1:0] HALF     = ACC_W'(1) << (SH - 1);
   localparam logic signed [ACC_W-1:0] SUM_MAX  = ACC_W'(32767);
   localparam logic signed [ACC_W-1:0] SUM_MIN  = ACC_W'(-32768);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      MAC    = 2'd1,
      UPDATE = 2'd2,
      OUT    = 2'd3
   } state_e;

   state_e                  state_q, state_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic signed [DW-1:0]    w_q, w_d, x_q, x_d, y_q, y_d, z_q, z_d;
   logic signed [DW-1:0]    gx_q, gx_d, gy_q, gy_d, gz_q, gz_d;
   logic signed [ACC_W-1:0] acc_q [4];
   logic signed [ACC_W-1:0] acc_d [4];
   logic                    out_valid_q, out_valid_d;
   logic                    sat_q, sat_d;

   logic signed [DW-1:0]    op_a, op_b;
   logic                    op_neg;
   logic [1:0]              op_sel;
   logic signed [PW-1:0]    prod;
   logic signed [ACC_W-1:0] prod_ext, term;
   logic [DW:0]             upd_w, upd_x, upd_y, upd_z;

   // Round-half-up scaled increment added to one component, saturated to Q1.15; MSB flags saturation.
   function automatic logic [DW:0] upd(input logic signed [DW-1:0]    q,
                                       input logic signed [ACC_W-1:0] acc);
      logic signed [ACC_W-1:0] delta;
      logic signed [ACC_W-1:0] sum;
      delta = (acc + HALF) >>> SH;
      sum   = delta + ACC_W'(q);
      if (sum > SUM_MAX)      upd = {1'b1, Q_MAX};
      else if (sum < SUM_MIN) upd = {1'b1, Q_MIN};
      else                    upd = {1'b0, sum[DW-1:0]};
   endfunction

   assign in_ready     = (state_q == IDLE) && !renorm_valid;
   assign renorm_ready = (state_q == IDLE);
   assign out_valid    = out_valid_q;
   assign sat_flag     = sat_q;
   assign w_out        = w_q;
   assign x_out        = x_q;
   assign y_out        = y_q;
   assign z_out        = z_q;

   // Term schedule of q (x) (0,w): operands, sign and destination accumulator per MAC index.
   always_comb begin
      op_a   = '0;
      op_b   = '0;
      op_neg = 1'b0;
      op_sel = 2'd0;
      case (idx_q)
         4'd0:  begin op_a = x_q; op_b = gx_q; op_neg = 1'b1; op_sel = 2'd0; end
         4'd1:  begin op_a = y_q; op_b = gy_q; op_neg = 1'b1; op_sel = 2'd0; end
         4'd2:  begin op_a = z_q; op_b = gz_q; op_neg = 1'b1; op_sel = 2'd0; end
         4'd3:  begin op_a = w_q; op_b = gx_q; op_neg = 1'b0; op_sel = 2'd1; end
         4'd4:  begin op_a = y_q; op_b = gz_q; op_neg = 1'b0; op_sel = 2'd1; end
         4'd5:  begin op_a = z_q; op_b = gy_q; op_neg = 1'b1; op_sel = 2'd1; end
         4'd6:  begin op_a = w_q; op_b = gy_q; op_neg = 1'b0; op_sel = 2'd2; end
         4'd7:  begin op_a = x_q; op_b = gz_q; op_neg = 1'b1; op_sel = 2'd2; end
         4'd8:  begin op_a = z_q; op_b = gx_q; op_neg = 1'b0; op_sel = 2'd2; end
         4'd9:  begin op_a = w_q; op_b = gz_q; op_neg = 1'b0; op_sel = 2'd3; end
         4'd10: begin op_a = x_q; op_b = gy_q; op_neg = 1'b0; op_sel = 2'd3; end
         4'd11: begin op_a = y_q; op_b = gx_q; op_neg = 1'b1; op_sel = 2'd3; end
         default: ;
      endcase
   end

   assign prod     = op_a * op_b;
   assign prod_ext = $signed({{(ACC_W - PW){prod[PW-1]}}, prod});
   assign term     = op_neg ? -prod_ext : prod_ext;

   assign upd_w = upd(w_q, acc_q[0]);
   assign upd_x = upd(x_q, acc_q[1]);
   assign upd_y = upd(y_q, acc_q[2]);
   assign upd_z = upd(z_q, acc_q[3]);

   // Next-state and datapath update.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      w_d         = w_q;
      x_d         = x_q;
      y_d         = y_q;
      z_d         = z_q;
      gx_d        = gx_q;
      gy_d        = gy_q;
      gz_d        = gz_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      sat_d       = sat_q;
      case (state_q)
         IDLE: begin
            if (renorm_valid) begin
               w_d = renorm_w;
               x_d = renorm_x;
               y_d = renorm_y;
               z_d = renorm_z;
            end else if (in_valid) begin
               gx_d    = gx_in;
               gy_d    = gy_in;
               gz_d    = gz_in;
               idx_d   = '0;
               state_d = MAC;
               for (int i = 0; i < 4; i++) acc_d[i] = '0;
            end
         end
         MAC: begin
            acc_d[op_sel] = acc_q[op_sel] + term;
            idx_d         = idx_q + IW'(1);
            if (idx_q == LAST_IDX) state_d = UPDATE;
         end
         UPDATE: begin
            w_d         = upd_w[DW-1:0];
            x_d         = upd_x[DW-1:0];
            y_d         = upd_y[DW-1:0];
            z_d         = upd_z[DW-1:0];
            sat_d       = upd_w[DW] | upd_x[DW] | upd_y[DW] | upd_z[DW];
            out_valid_d = 1'b1;
            state_d     = OUT;
         end
         OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         w_q         <= Q_MAX;
         x_q         <= '0;
         y_q         <= '0;
         z_q         <= '0;
         gx_q        <= '0;
         gy_q        <= '0;
         gz_q        <= '0;
         for (int i = 0; i < 4; i++) acc_q[i] <= '0;
         out_valid_q <= 1'b0;
         sat_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         w_q         <= w_d;
         x_q         <= x_d;
         y_q         <= y_d;
         z_q         <= z_d;
         gx_q        <= gx_d;
         gy_q        <= gy_d;
         gz_q        <= gz_d;
         for (int i = 0; i < 4; i++) acc_q[i] <= acc_d[i];
         out_valid_q <= out_valid_d;
         sat_q       <= sat_d;
      end
   end

endmodule

// File: tb/tb_quaternion_integrator.sv
// Self-checking bench for quaternion_integrator: directed corner cases plus random samples
// compared against an arithmetic model of the quaternion update.
module tb_quaternion_integrator;

   localparam int S = 12 + 1 + 8;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               in_valid, in_ready;
   logic signed [15:0] gx_in, gy_in, gz_in;
   logic               renorm_valid, renorm_ready;
   logic signed [15:0] renorm_w, renorm_x, renorm_y, renorm_z;
   logic               out_valid, out_ready;
   logic signed [15:0] w_out, x_out, y_out, z_out;
   logic               sat_flag;

   int total = 0;
   int bad   = 0;
   int mq[4];
   bit msat;
   logic signed [15:0] cur_g[3];

   quaternion_integrator #(.DT_SHIFT(8), .ACC_W(36)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .gx_in(gx_in), .gy_in(gy_in), .gz_in(gz_in),
      .renorm_valid(renorm_valid), .renorm_ready(renorm_ready),
      .renorm_w(renorm_w), .renorm_x(renorm_x), .renorm_y(renorm_y), .renorm_z(renorm_z),
      .out_valid(out_valid), .out_ready(out_ready),
      .w_out(w_out), .x_out(x_out), .y_out(y_out), .z_out(z_out),
      .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   initial begin
      #(200000 * 10);
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input longint got, input longint exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Reference: q + round_half_up(q (x) (0,w) / 2^S), clamped to Q1.15.
   function automatic void model_step(input int a, input int b, input int c);
      longint acc[4];
      longint d, s;
      bit any;
      acc[0] = -longint'(mq[1]) * a - longint'(mq[2]) * b - longint'(mq[3]) * c;
      acc[1] =  longint'(mq[0]) * a + longint'(mq[2]) * c - longint'(mq[3]) * b;
      acc[2] =  longint'(mq[0]) * b - longint'(mq[1]) * c + longint'(mq[3]) * a;
      acc[3] =  longint'(mq[0]) * c + longint'(mq[1]) * b - longint'(mq[2]) * a;
      any = 1'b0;
      for (int i = 0; i < 4; i++) begin
         d = (acc[i] + (longint'(1) << (S - 1))) >>> S;
         s = mq[i] + d;
         if (s > 32767) begin s = 32767; any = 1'b1; end
         else if (s < -32768) begin s = -32768; any = 1'b1; end
         mq[i] = int'(s);
      end
      msat = any;
   endfunction

   task automatic check_q(input string tag);
      check({tag, "_w"}, w_out, mq[0]);
      check({tag, "_x"}, x_out, mq[1]);
      check({tag, "_y"}, y_out, mq[2]);
      check({tag, "_z"}, z_out, mq[3]);
   endtask

   task automatic renorm(input logic signed [15:0] a, b, c, d);
      @(negedge clk);
      renorm_valid = 1'b1;
      renorm_w = a; renorm_x = b; renorm_y = c; renorm_z = d;
      #1;
      check("rn_ready", renorm_ready, 1);
      check("rn_in_ready", in_ready, 0);
      @(posedge clk); #1;
      renorm_valid = 1'b0;
      mq[0] = a; mq[1] = b; mq[2] = c; mq[3] = d;
      check_q("rn");
      check("rn_sat", sat_flag, msat);
   endtask

   task automatic send(input logic signed [15:0] a, b, c);
      int n;
      @(negedge clk);
      gx_in = a; gy_in = b; gz_in = c;
      cur_g[0] = a; cur_g[1] = b; cur_g[2] = c;
      in_valid = 1'b1;
      n = 0;
      #1;
      while (!in_ready && n < 40) begin
         @(negedge clk); #1;
         n++;
      end
      if (!in_ready) check("accept_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic collect(input int hold);
      int lat;
      lat = 0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge clk); #1;
         if (out_valid) begin
            lat = n;
            break;
         end
         check_q("mac_hold");
      end
      check("latency", lat, 13);
      model_step(cur_g[0], cur_g[1], cur_g[2]);
      check_q("upd");
      check("upd_sat", sat_flag, msat);
      if (hold > 0) begin
         renorm_valid = 1'b1;
         renorm_w = 16'($urandom); renorm_x = 16'($urandom);
         renorm_y = 16'($urandom); renorm_z = 16'($urandom);
      end
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check("bp_valid", out_valid, 1);
         check("bp_rr", renorm_ready, 0);
         check_q("bp");
         check("bp_sat", sat_flag, msat);
      end
      renorm_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("hs_valid", out_valid, 0);
      check("hs_in_ready", in_ready, 1);
      check_q("hs");
   endtask

   initial begin
      rst_n = 1'b1;
      in_valid = 1'b0; gx_in = '0; gy_in = '0; gz_in = '0;
      renorm_valid = 1'b0; renorm_w = '0; renorm_x = '0; renorm_y = '0; renorm_z = '0;
      out_ready = 1'b0;
      mq[0] = 32767; mq[1] = 0; mq[2] = 0; mq[3] = 0; msat = 1'b0;
      #3 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_q("rst");
      check("rst_valid", out_valid, 0);
      check("rst_sat", sat_flag, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_rr", renorm_ready, 1);

      // zero rate
      send(16'sd0, 16'sd0, 16'sd0);
      collect(0);
      check("zero_w", w_out, 32767);

      // single-axis step, twice
      send(16'sh1000, 16'sd0, 16'sd0);
      collect(0);
      check("step1_x", x_out, 64);
      send(16'sh1000, 16'sd0, 16'sd0);
      collect(0);
      check("step2_x", x_out, 128);
      check("step2_w", w_out, 32767);

      // saturation
      renorm(16'sh7FFF, 16'sh7FFF, 16'sd0, 16'sd0);
      send(16'sh7FFF, 16'sd0, 16'sd0);
      collect(0);
      check("sat_x", x_out, 32767);
      check("sat_flag", sat_flag, 1);

      // renorm/in_valid collision
      @(negedge clk);
      renorm_valid = 1'b1;
      renorm_w = 16'sh4000; renorm_x = 16'sh2000; renorm_y = -16'sh2000; renorm_z = 16'sh1000;
      in_valid = 1'b1; gx_in = 16'sh0800; gy_in = -16'sh0400; gz_in = 16'sh0200;
      #1;
      check("col_in_ready", in_ready, 0);
      check("col_rr", renorm_ready, 1);
      @(posedge clk); #1;
      renorm_valid = 1'b0;
      mq[0] = 16'sh4000; mq[1] = 16'sh2000; mq[2] = -16'sh2000; mq[3] = 16'sh1000;
      check_q("col");
      check("col_valid", out_valid, 0);
      send(16'sh0800, -16'sh0400, 16'sh0200);
      collect(0);

      // backpressure
      send(-16'sh3000, 16'sh1234, 16'sh0777);
      collect(5);

      // reset during MAC
      renorm(16'sh5A82, 16'sh5A82, 16'sd0, 16'sd0);
      send(16'sh1000, 16'sh0800, -16'sh0400);
      repeat (5) @(posedge clk);
      #1 check_q("pre_rst");
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      mq[0] = 32767; mq[1] = 0; mq[2] = 0; mq[3] = 0; msat = 1'b0;
      check_q("mid_rst");
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_sat", sat_flag, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("post_rst_in_ready", in_ready, 1);
      send(16'sd0, 16'sd0, 16'sd0);
      collect(0);

      // randomized samples with occasional renorm loads and backpressure
      for (int k = 0; k < 30; k++) begin
         logic signed [15:0] ga, gb, gc;
         if ($urandom_range(0, 3) == 0)
            renorm(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
         ga = $signed(16'($urandom)) >>> $urandom_range(0, 6);
         gb = $signed(16'($urandom)) >>> $urandom_range(0, 6);
         gc = $signed(16'($urandom)) >>> $urandom_range(0, 6);
         send(ga, gb, gc);
         collect(int'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
